dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 (CPU load/store unit) and port 1 (DMA/debug loader).
- Arbitrates per cycle, registers the winning command into an issue stage, drives the memory's address, write-data, write-enable and read-enable lines, and returns read data to the winner.
- Sits between the requesters and the data memory. Fully pipelined: one access per cycle.

Parameters:
- ADDR_W, 16, requester/memory address width
- DATA_W, 16, data width
- RAM_ADDR_W, 3, address bits actually decoded by the memory (8 words)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- p0_req / p1_req  in  1  request valid
- p0_we / p1_we  in  1  1 = write, 0 = read
- p0_addr / p1_addr  in  ADDR_W  word address
- p0_wdata / p1_wdata  in  DATA_W  write data
- p0_gnt / p1_gnt  out  1  request accepted this cycle (combinational)
- p0_rsp_valid / p1_rsp_valid  out  1  one-cycle response pulse
- p0_rsp_rdata / p1_rsp_rdata  out  DATA_W  read data; 0 for writes
- p0_rsp_err / p1_rsp_err  out  1  address out of range
- mem_access_addr  out  ADDR_W  to memory
- mem_write_data  out  DATA_W  to memory
- mem_write_en  out  1  to memory
- mem_read  out  1  to memory
- mem_read_data  in  DATA_W  combinational read data from memory

Behaviour:
- Handshake: requester holds req/we/addr/wdata stable until gnt. Transfer occurs on the edge where req && gnt. At most one gnt per cycle. gnt=0 when rst_n=0.
- Arbitration: if only one req, grant it. If both, round-robin: grant the port not granted most recently.
  - last_gnt register updates only on an actual grant.
  - last_gnt resets to 1, so port 0 wins the first contest.
- Stage S1 (issue) registers: s1_vld, s1_port, s1_we, s1_addr, s1_wdata, s1_err.
  - Loaded on a grant edge; s1_vld=0 otherwise.
  - s1_err = (addr[ADDR_W-1:RAM_ADDR_W] != 0).
- Memory drive from S1:
  - mem_access_addr = s1_addr
  - mem_write_data = s1_wdata
  - mem_write_en = s1_vld & s1_we & ~s1_err
  - mem_read = s1_vld & ~s1_we & ~s1_err
  - All memory outputs are 0 when S1 is idle.
  - Out-of-range writes are suppressed (never alias into low words).
- Stage S2 (response): on each edge, s2 captures s1_vld, s1_port, s1_err, and rdata.
  - rdata = mem_read_data for reads, 0 for writes and errors.
  - px_rsp_valid = s2_vld & (s2_port==x). Only the owning port sees rdata/err; the other port's rdata=0, err=0.
- Latency: grant at edge E0 -> memory access during cycle E0..E1 (write commits at E1) -> rsp_valid high for cycle E1..E2. Fixed at 2 edges.
- No response backpressure: requesters must accept rsp_valid pulses.
- Read-after-write (same address, back-to-back grants): the read returns the new data, because the write commits at E1 before the read's S1 cycle. No forwarding logic is needed.
- Reset: async clear of s1_*, s2_*, and all outputs to 0; last_gnt=1.
  - Reset asserted with a write in S1 drops mem_write_en immediately; the write must not commit.
  - In-flight responses are lost.

Optional Feature:
- DMEM_ARB_FIXED_PRIO_EN
  - Defined: port 0 always wins when both request; last_gnt is not implemented. Port 1 may starve.
  - Undefined: round-robin as above.

Decomposition:
- Shared header (project parameter include): DMEM_ADDR_W, DMEM_DATA_W, DMEM_RAM_ADDR_W, port-index constants PORT_CPU=0 and PORT_DMA=1.
- One sub-module: rr_arb2 (two-input round-robin arbiter: req[1:0] -> gnt[1:0], last_gnt state, fixed-priority macro handled inside).
- Pipeline stages stay in dmem_arbiter.

Test Plan:
- Reset then p0 write addr=3 data=0xA5A5 -> p0_gnt same cycle; mem_write_en=1 with addr=3 the next cycle; p0_rsp_valid 2 edges after grant with rdata=0, err=0.
- p0 write addr=5 data=0x1234, then p0 read addr=5 on the next cycle -> read response rdata=0x1234 (RAW, back-to-back).
- p0 and p1 both request continuously for 6 cycles -> gnt pattern p0,p1,p0,p1,p0,p1; each response arrives on the correct port. With DMEM_ARB_FIXED_PRIO_EN defined -> all six grants go to p0.
- p1 write addr=0x0009 data=0xFFFF -> mem_write_en stays 0, word 1 unchanged, p1_rsp_err=1; a following read of addr 1 returns the old value.
- p1 read addr=2 while p0 is idle -> p1_gnt=1, p0_rsp_valid never asserts, p1_rsp_rdata matches memory word 2.
- Assert rst_n=0 mid-cycle while a write to addr=4 is in S1 -> mem_write_en falls immediately, word 4 unchanged, no rsp_valid. After release, the first contested request is granted to p0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared parameters for the data-memory arbiter: default widths and port indices.
package dmem_arbiter_pkg;

    localparam int unsigned DMEM_ADDR_W     = 16;
    localparam int unsigned DMEM_DATA_W     = 16;
    localparam int unsigned DMEM_RAM_ADDR_W = 3;

    // Requester indices; also the encoding of the stored "last granted" port.
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input arbiter. Round-robin by default; defining DMEM_ARB_FIXED_PRIO_EN
// makes port 0 win every contest and removes the last-grant state.
module dmem_arbiter_rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // No grant can be issued while reset is asserted.
    logic [1:0] req_act;
    assign req_act = req & {2{rst_n}};

`ifdef DMEM_ARB_FIXED_PRIO_EN

    logic unused_clk;
    assign unused_clk = clk;

    // Port 0 always has priority.
    always_comb begin
        gnt = 2'b00;
        if (req_act[0]) begin
            gnt = 2'b01;
        end else if (req_act[1]) begin
            gnt = 2'b10;
        end
    end

`else

    logic last_gnt_q, last_gnt_d;

    // Grant the sole requester, or on contention the port not granted most recently.
    always_comb begin
        gnt        = 2'b00;
        last_gnt_d = last_gnt_q;
        case (req_act)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_gnt_q == PORT_DMA) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        if (gnt[0]) begin
            last_gnt_d = PORT_CPU;
        end else if (gnt[1]) begin
            last_gnt_d = PORT_DMA;
        end
    end

    // Last-grant register; resetting to the DMA port lets the CPU win the first contest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= PORT_DMA;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares a single-port memory between the CPU (port 0) and
// the DMA/debug loader (port 1). Grant -> issue stage (S1) -> response stage (S2),
// one access per cycle. Optional macro DMEM_ARB_FIXED_PRIO_EN selects fixed priority.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = DMEM_ADDR_W,
    parameter int unsigned DATA_W     = DMEM_DATA_W,
    parameter int unsigned RAM_ADDR_W = DMEM_RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rsp_rdata,
    output logic              p0_rsp_err,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rsp_rdata,
    output logic              p1_rsp_err,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    logic [1:0] req, gnt;

    logic              s1_vld_q, s1_vld_d;
    logic              s1_port_q, s1_port_d;
    logic              s1_we_q, s1_we_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
    logic [DATA_W-1:0] s1_wdata_q, s1_wdata_d;
    logic              s1_err_q, s1_err_d;

    logic              s2_vld_q, s2_vld_d;
    logic              s2_port_q, s2_port_d;
    logic              s2_err_q, s2_err_d;
    logic [DATA_W-1:0] s2_rdata_q, s2_rdata_d;

    assign req = {p1_req, p0_req};

    dmem_arbiter_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt)
    );

    assign p0_gnt = gnt[0];
    assign p1_gnt = gnt[1];

    // Issue-stage load: capture the winner, or clear everything so idle cycles drive zeros.
    always_comb begin
        s1_vld_d   = 1'b0;
        s1_port_d  = PORT_CPU;
        s1_we_d    = 1'b0;
        s1_addr_d  = '0;
        s1_wdata_d = '0;
        if (gnt[1]) begin
            s1_vld_d   = 1'b1;
            s1_port_d  = PORT_DMA;
            s1_we_d    = p1_we;
            s1_addr_d  = p1_addr;
            s1_wdata_d = p1_wdata;
        end else if (gnt[0]) begin
            s1_vld_d   = 1'b1;
            s1_port_d  = PORT_CPU;
            s1_we_d    = p0_we;
            s1_addr_d  = p0_addr;
            s1_wdata_d = p0_wdata;
        end
        // Any address bit above the decoded range means the access would alias.
        s1_err_d = s1_vld_d && (s1_addr_d[ADDR_W-1:RAM_ADDR_W] != '0);
    end

    // Issue-stage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_port_q  <= PORT_CPU;
            s1_we_q    <= 1'b0;
            s1_addr_q  <= '0;
            s1_wdata_q <= '0;
            s1_err_q   <= 1'b0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_port_q  <= s1_port_d;
            s1_we_q    <= s1_we_d;
            s1_addr_q  <= s1_addr_d;
            s1_wdata_q <= s1_wdata_d;
            s1_err_q   <= s1_err_d;
        end
    end

    // Memory drive; out-of-range accesses are suppressed so they never touch low words.
    always_comb begin
        mem_access_addr = s1_addr_q;
        mem_write_data  = s1_wdata_q;
        mem_write_en    = s1_vld_q & s1_we_q & ~s1_err_q;
        mem_read        = s1_vld_q & ~s1_we_q & ~s1_err_q;
    end

    // Response-stage next state: read data only for successful reads.
    always_comb begin
        s2_vld_d   = s1_vld_q;
        s2_port_d  = s1_port_q;
        s2_err_d   = s1_vld_q & s1_err_q;
        s2_rdata_d = mem_read ? mem_read_data : '0;
    end

    // Response-stage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q   <= 1'b0;
            s2_port_q  <= PORT_CPU;
            s2_err_q   <= 1'b0;
            s2_rdata_q <= '0;
        end else begin
            s2_vld_q   <= s2_vld_d;
            s2_port_q  <= s2_port_d;
            s2_err_q   <= s2_err_d;
            s2_rdata_q <= s2_rdata_d;
        end
    end

    // Route the response to its owner only; the other port sees zeros.
    always_comb begin
        p0_rsp_valid = s2_vld_q & (s2_port_q == PORT_CPU);
        p1_rsp_valid = s2_vld_q & (s2_port_q == PORT_DMA);
        p0_rsp_rdata = p0_rsp_valid ? s2_rdata_q : '0;
        p1_rsp_rdata = p1_rsp_valid ? s2_rdata_q : '0;
        p0_rsp_err   = p0_rsp_valid & s2_err_q;
        p1_rsp_err   = p1_rsp_valid & s2_err_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: an 8-word memory in the environment, a
// transaction-level reference model checked every cycle, plus directed literal checks.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [15:0] p0_addr = '0, p0_wdata = '0;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [15:0] p1_addr = '0, p1_wdata = '0;
    logic        p0_gnt, p1_gnt;
    logic        p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err;
    logic [15:0] p0_rsp_rdata, p1_rsp_rdata;
    logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
    logic        mem_write_en, mem_read;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .p0_req          (p0_req),
        .p0_we           (p0_we),
        .p0_addr         (p0_addr),
        .p0_wdata        (p0_wdata),
        .p1_req          (p1_req),
        .p1_we           (p1_we),
        .p1_addr         (p1_addr),
        .p1_wdata        (p1_wdata),
        .p0_gnt          (p0_gnt),
        .p1_gnt          (p1_gnt),
        .p0_rsp_valid    (p0_rsp_valid),
        .p0_rsp_rdata    (p0_rsp_rdata),
        .p0_rsp_err      (p0_rsp_err),
        .p1_rsp_valid    (p1_rsp_valid),
        .p1_rsp_rdata    (p1_rsp_rdata),
        .p1_rsp_err      (p1_rsp_err),
        .mem_access_addr (mem_access_addr),
        .mem_write_data  (mem_write_data),
        .mem_write_en    (mem_write_en),
        .mem_read        (mem_read),
        .mem_read_data   (mem_read_data)
    );

    // Environment memory: 8 words, combinational read, write on the clock edge.
    logic        ram_init = 1'b1;
    logic [15:0] ram [8];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 8; i++) ram[i] <= 16'h1000 + 16'(i);
        end else if (mem_write_en) begin
            ram[mem_access_addr[2:0]] <= mem_write_data;
        end
    end
    assign mem_read_data = ram[mem_access_addr[2:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          issue;  // cycle index during which the memory access happens
        logic        port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } txn_t;

    txn_t        q[$];
    txn_t        t;
    int          cyc = 0;
    logic        m_last = 1'b1;
    logic [15:0] model_mem [8];
    logic        e_g0, e_g1, in_rng;
    int          ii;

    // Compare process: at each falling edge check outputs, then advance the model
    // with the inputs that the coming rising edge will sample.
    always @(negedge clk) begin
        if (cyc == 0) for (int i = 0; i < 8; i++) model_mem[i] = 16'h1000 + 16'(i);
        if (!rst_n) begin
            q.delete();
            m_last = 1'b1;
            chk("rst_gnt", {p1_gnt, p0_gnt}, 0);
            chk("rst_mem", {mem_write_en, mem_read, mem_access_addr, mem_write_data}, 0);
            chk("rst_rsp", {p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err,
                            p0_rsp_rdata | p1_rsp_rdata}, 0);
        end else begin
            e_g0 = 1'b0;
            e_g1 = 1'b0;
            if (p0_req && p1_req) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                e_g0 = 1'b1;
`else
                if (m_last) e_g0 = 1'b1;
                else e_g1 = 1'b1;
`endif
            end else begin
                e_g0 = p0_req;
                e_g1 = p1_req;
            end
            chk("gnt", {p1_gnt, p0_gnt}, {e_g1, e_g0});

            // Access expected in the memory during this cycle.
            ii = -1;
            for (int i = 0; i < q.size(); i++) if (q[i].issue == cyc) ii = i;
            if (ii >= 0) begin
                in_rng = q[ii].addr < 16'd8;
                chk("mem_addr", mem_access_addr, q[ii].addr);
                chk("mem_wdata", mem_write_data, q[ii].wdata);
                chk("mem_we", mem_write_en, q[ii].we && in_rng);
                chk("mem_rd", mem_read, !q[ii].we && in_rng);
                if (!q[ii].we && in_rng) q[ii].rdata = model_mem[q[ii].addr[2:0]];
            end else begin
                chk("mem_idle", {mem_write_en, mem_read, mem_access_addr, mem_write_data}, 0);
            end

            // Response expected this cycle: the access from the previous cycle.
            t.issue = -1;
            for (int i = 0; i < q.size(); i++) if (q[i].issue == cyc - 1) t = q[i];
            if (t.issue >= 0) begin
                chk("rsp_valid", {p1_rsp_valid, p0_rsp_valid}, t.port ? 2'b10 : 2'b01);
                chk("rsp_rdata0", p0_rsp_rdata, t.port ? 16'h0 : t.rdata);
                chk("rsp_rdata1", p1_rsp_rdata, t.port ? t.rdata : 16'h0);
                chk("rsp_err", {p1_rsp_err, p0_rsp_err},
                    (t.addr < 16'd8) ? 2'b00 : (t.port ? 2'b10 : 2'b01));
            end else begin
                chk("rsp_idle", {p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err,
                                 p0_rsp_rdata | p1_rsp_rdata}, 0);
            end

            // Writes commit at the end of their access cycle.
            if (ii >= 0 && q[ii].we && q[ii].addr < 16'd8) model_mem[q[ii].addr[2:0]] = q[ii].wdata;
            while (q.size() > 0 && q[0].issue < cyc) void'(q.pop_front());

            if (e_g0 || e_g1) begin
                t.issue = cyc + 1;
                t.port  = e_g1;
                t.we    = e_g1 ? p1_we : p0_we;
                t.addr  = e_g1 ? p1_addr : p0_addr;
                t.wdata = e_g1 ? p1_wdata : p0_wdata;
                t.rdata = 16'h0;
                q.push_back(t);
                m_last = e_g1;
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_req(output logic req, output logic we, output logic [15:0] addr,
                            output logic [15:0] wdata);
        req   = ($urandom_range(0, 2) != 0);
        we    = 1'($urandom_range(0, 1));
        addr  = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
        wdata = 16'($urandom);
    endtask

    logic [5:0] g0_log, g1_log;
    logic       sg0, sg1;

    initial begin
        step();
        step();
        step();
        ram_init = 1'b0;
        rst_n    = 1'b1;
        step();

        // Single write: grant now, memory write next cycle, response after two edges.
        p0_req = 1; p0_we = 1; p0_addr = 16'd3; p0_wdata = 16'hA5A5;
        #1 chk("t1_gnt", p0_gnt, 1);
        step();
        p0_req = 0;
        chk("t1_mem_we", mem_write_en, 1);
        chk("t1_mem_addr", mem_access_addr, 16'd3);
        step();
        chk("t1_rsp", {p0_rsp_valid, p0_rsp_err, p0_rsp_rdata}, {2'b10, 16'h0});
        chk("t1_ram", ram[3], 16'hA5A5);

        // Back-to-back write then read of the same word.
        p0_req = 1; p0_we = 1; p0_addr = 16'd5; p0_wdata = 16'h1234;
        step();
        p0_we = 0;
        step();
        p0_req = 0;
        step();
        chk("t2_raw", {p0_rsp_valid, p0_rsp_rdata}, {1'b1, 16'h1234});

        // Reset, then six cycles of contention.
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        p0_req = 1; p0_we = 0; p0_addr = 16'd0;
        p1_req = 1; p1_we = 0; p1_addr = 16'd2;
        for (int i = 0; i < 6; i++) begin
            #1;
            g0_log[i] = p0_gnt;
            g1_log[i] = p1_gnt;
            step();
        end
        p0_req = 0; p1_req = 0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        chk("t3_p0_pattern", g0_log, 6'b111111);
        chk("t3_p1_pattern", g1_log, 6'b000000);
`else
        chk("t3_p0_pattern", g0_log, 6'b010101);
        chk("t3_p1_pattern", g1_log, 6'b101010);
`endif
        step();
        step();

        // Out-of-range write is suppressed and flagged.
        p1_req = 1; p1_we = 1; p1_addr = 16'h0009; p1_wdata = 16'hFFFF;
        #1 chk("t4_gnt", p1_gnt, 1);
        step();
        p1_req = 0;
        chk("t4_mem_we", mem_write_en, 0);
        step();
        chk("t4_err", {p1_rsp_valid, p1_rsp_err}, 2'b11);
        chk("t4_ram", ram[1], 16'h1001);
        p1_req = 1; p1_we = 0; p1_addr = 16'd1;
        step();
        p1_req = 0;
        step();
        chk("t4_read_old", {p1_rsp_valid, p1_rsp_err, p1_rsp_rdata}, {2'b10, 16'h1001});

        // Lone DMA read.
        p1_req = 1; p1_we = 0; p1_addr = 16'd2;
        #1 chk("t5_gnt", {p1_gnt, p0_gnt}, 2'b10);
        step();
        p1_req = 0;
        step();
        chk("t5_rsp", {p0_rsp_valid, p1_rsp_valid, p1_rsp_rdata}, {2'b01, 16'h1002});

        // Reset asserted mid-cycle with a write in the issue stage.
        p0_req = 1; p0_we = 1; p0_addr = 16'd4; p0_wdata = 16'hBEEF;
        step();
        p0_req = 0;
        chk("t6_we_before", mem_write_en, 1);
        #1 rst_n = 0;
        #1 chk("t6_we_dropped", mem_write_en, 0);
        step();
        chk("t6_ram", ram[4], 16'h1004);
        chk("t6_no_rsp", {p0_rsp_valid, p1_rsp_valid}, 2'b00);
        rst_n = 1;
        p0_req = 1; p0_we = 0; p0_addr = 16'd4;
        p1_req = 1; p1_we = 0; p1_addr = 16'd6;
        #1 chk("t6_first_contest", {p1_gnt, p0_gnt}, 2'b01);
        step();
        p0_req = 0; p1_req = 0;
        step();
        step();

        // Random traffic; each requester holds its command until granted.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            sg0 = p0_gnt;
            sg1 = p1_gnt;
            step();
            if (!p0_req || sg0) rand_req(p0_req, p0_we, p0_addr, p0_wdata);
            if (!p1_req || sg1) rand_req(p1_req, p1_we, p1_addr, p1_wdata);
        end
        p0_req = 0; p1_req = 0;
        step();
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
